// File: rtl/sci_rxbuf.sv
// sci_rxbuf: polls the SCI receive status, drains received bytes into a
// DEPTH-entry FIFO and presents them to the CPU through a small register set
// (addr 0 = status, 1 = data/pop, 2 = control/flush).
// Optional feature: define SCI_RXBUF_OVERRUN_EN to get a sticky overrun flag
// in status bit 7 (set when rdrf is seen while the FIFO is full).
module sci_rxbuf #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic       clk,
  input  logic       resetn,
  output logic       sci_IOsel,
  output logic [2:0] sci_addr,
  output logic       sci_read,
  input  logic [7:0] sci_dataout,
  input  logic       IOsel,
  input  logic [2:0] addr,
  input  logic       read,
  input  logic       write,
  input  logic [7:0] datain,
  output logic [7:0] dataout
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  localparam logic [2:0] SCI_STATUS = 3'd4;
  localparam logic [2:0] SCI_DATA   = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STAT  = 2'd1,
    S_DREAD = 2'd2,
    S_GAP   = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic       sci_iosel_d;
  logic [2:0] sci_addr_d;
  logic       sci_read_d;

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic pop_prev_q, flush_prev_q;
  logic pop_lvl, flush_lvl;
  logic pop, flush, push;
  logic full, empty, rdrf;
  logic ovr;

  logic unused_datain;
  assign unused_datain = ^datain[7:1];

  assign rdrf  = sci_dataout[0];
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // CPU strobe decode; pop and flush act once per strobe (rising edge only)
  assign pop_lvl   = IOsel & read & (addr == 3'd1);
  assign flush_lvl = IOsel & write & (addr == 3'd2) & datain[0];
  assign pop       = pop_lvl & ~pop_prev_q & ~empty;
  assign flush     = flush_lvl & ~flush_prev_q;
  // A full FIFO only accepts a byte when a pop frees the slot in the same cycle
  assign push      = (state_q == S_DREAD) & (~full | pop);

  // Poll FSM state register and registered SCI port outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      sci_IOsel <= 1'b0;
      sci_addr  <= 3'd0;
      sci_read  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sci_IOsel <= sci_iosel_d;
      sci_addr  <= sci_addr_d;
      sci_read  <= sci_read_d;
    end
  end

  // Poll FSM next state: drain the data register only if there is room
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_STAT;
      S_STAT:  state_d = (rdrf && !full) ? S_DREAD : S_IDLE;
      S_DREAD: state_d = S_GAP;
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // SCI port decode from the next state so the outputs are registered
  always_comb begin
    sci_iosel_d = 1'b0;
    sci_addr_d  = 3'd0;
    sci_read_d  = 1'b0;
    case (state_d)
      S_STAT: begin
        sci_iosel_d = 1'b1;
        sci_addr_d  = SCI_STATUS;
        sci_read_d  = 1'b1;
      end
      S_DREAD: begin
        sci_iosel_d = 1'b1;
        sci_addr_d  = SCI_DATA;
        sci_read_d  = 1'b1;
      end
      default: begin
        sci_iosel_d = 1'b0;
        sci_addr_d  = 3'd0;
        sci_read_d  = 1'b0;
      end
    endcase
  end

  // FIFO pointer/count update; flush overrides push and pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO pointers, count and CPU strobe edge detectors
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pop_prev_q   <= 1'b0;
      flush_prev_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pop_prev_q   <= pop_lvl;
      flush_prev_q <= flush_lvl;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= sci_dataout;
  end

`ifdef SCI_RXBUF_OVERRUN_EN
  logic ovr_q, ovr_d;

  // Sticky overrun: rdrf seen while full; only flush or reset clears it
  always_comb begin
    ovr_d = ovr_q;
    if (flush) ovr_d = 1'b0;
    else if ((state_q == S_STAT) && rdrf && full) ovr_d = 1'b1;
  end

  // Overrun flag register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ovr_q <= 1'b0;
    else         ovr_q <= ovr_d;
  end

  assign ovr = ovr_q;
`else
  assign ovr = 1'b0;
`endif

  // CPU read mux: status or head-of-FIFO, 0 when not selected for a read
  always_comb begin
    dataout = 8'h00;
    if (IOsel && read) begin
      case (addr)
        3'd0:    dataout = {ovr, full, ~empty, 5'(count_q)};
        3'd1:    dataout = empty ? 8'h00 : mem_q[rd_ptr_q];
        default: dataout = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_sci_rxbuf.sv
// Directed bench for sci_rxbuf with a simple SCI register-port model.
module tb_sci_rxbuf;

  logic       clk;
  logic       resetn;
  logic       sci_IOsel;
  logic [2:0] sci_addr;
  logic       sci_read;
  logic [7:0] sci_dataout;
  logic       IOsel;
  logic [2:0] addr;
  logic       read;
  logic       write;
  logic [7:0] datain;
  logic [7:0] dataout;

  logic       sci_rdrf;
  logic [7:0] sci_data;
  int         dread_cnt;
  int         n_chk;
  int         n_pass;

`ifdef SCI_RXBUF_OVERRUN_EN
  localparam logic [7:0] OVR_BIT = 8'h80;
`else
  localparam logic [7:0] OVR_BIT = 8'h00;
`endif

  sci_rxbuf #(.ADDR_W(4)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .sci_IOsel   (sci_IOsel),
    .sci_addr    (sci_addr),
    .sci_read    (sci_read),
    .sci_dataout (sci_dataout),
    .IOsel       (IOsel),
    .addr        (addr),
    .read        (read),
    .write       (write),
    .datain      (datain),
    .dataout     (dataout)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // SCI register port model
  always_comb begin
    sci_dataout = 8'h00;
    if (sci_IOsel && sci_read && sci_addr == 3'd4) sci_dataout = {7'b0, sci_rdrf};
    else if (sci_IOsel && sci_read && sci_addr == 3'd5) sci_dataout = sci_data;
  end

  // Count SCI data-register read cycles
  always @(posedge clk or negedge resetn) begin
    if (!resetn) dread_cnt <= dread_cnt;
    else if (sci_IOsel && sci_read && sci_addr == 3'd5) dread_cnt <= dread_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic cpu_rd(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    IOsel = 1'b1; read = 1'b1; addr = a;
    #1 d = dataout;
    @(negedge clk);
    IOsel = 1'b0; read = 1'b0; addr = 3'd0;
  endtask

  task automatic cpu_wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    IOsel = 1'b1; write = 1'b1; addr = a; datain = d;
    @(negedge clk);
    IOsel = 1'b0; write = 1'b0; addr = 3'd0; datain = 8'h00;
  endtask

  // Raise rdrf with byte b; mode 1 = CPU pop, 2 = flush, 3 = reset during DREAD
  task automatic sci_send(input logic [7:0] b, input int mode, output bit got);
    got = 1'b0;
    sci_data = b;
    sci_rdrf = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (sci_IOsel && sci_read && sci_addr == 3'd5) begin
        got = 1'b1;
        sci_rdrf = 1'b0;
        case (mode)
          1: begin IOsel = 1'b1; read = 1'b1; addr = 3'd1; end
          2: begin IOsel = 1'b1; write = 1'b1; addr = 3'd2; datain = 8'h01; end
          3: resetn = 1'b0;
          default: ;
        endcase
      end
    end
    if (!got) sci_rdrf = 1'b0;
    if (got && mode != 3) begin
      @(negedge clk);
      IOsel = 1'b0; read = 1'b0; write = 1'b0; addr = 3'd0; datain = 8'h00;
    end
  endtask

  initial begin
    logic [7:0] d;
    bit         got;
    int         ngot;
    int         dc;
    bit         seen;

    n_chk = 0; n_pass = 0; dread_cnt = 0;
    resetn = 1'b0; sci_rdrf = 1'b0; sci_data = 8'h00;
    IOsel = 1'b0; addr = 3'd0; read = 1'b0; write = 1'b0; datain = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_sci_read", 32'(sci_read), 32'h0);
    chk("rst_sci_iosel", 32'(sci_IOsel), 32'h0);
    chk("rst_sci_addr", 32'(sci_addr), 32'h0);
    IOsel = 1'b1; read = 1'b1; addr = 3'd0;
    #1 chk("rst_status", 32'(dataout), 32'h00);
    IOsel = 1'b0; read = 1'b0;
    chk("rst_dataout_idle", 32'(dataout), 32'h00);
    @(negedge clk);
    resetn = 1'b1;

    // Reset asserted mid-DREAD
    sci_send(8'h5A, 3, got);
    chk("rstmid_got_dread", 32'(got), 32'h1);
    #1;
    chk("rstmid_sci_read", 32'(sci_read), 32'h0);
    chk("rstmid_sci_iosel", 32'(sci_IOsel), 32'h0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (sci_read) seen = 1'b1;
    end
    chk("rstmid_read_seen", 32'(seen), 32'h1);
    chk("rstmid_first_addr", 32'(sci_addr), 32'h4);
    cpu_rd(3'd0, d); chk("rstmid_status", 32'(d), 32'h00);

    // Single byte
    dc = dread_cnt;
    sci_send(8'hA5, 0, got);
    chk("single_got", 32'(got), 32'h1);
    chk("single_dreads", 32'(dread_cnt - dc), 32'h1);
    cpu_rd(3'd0, d); chk("single_status", 32'(d), 32'h21);
    cpu_rd(3'd1, d); chk("single_data", 32'(d), 32'hA5);
    cpu_rd(3'd0, d); chk("single_status_after", 32'(d), 32'h00);

    // Fill to full, then an extra rdrf must not be drained
    ngot = 0;
    for (int i = 0; i < 16; i++) begin
      sci_send(8'(i), 0, got);
      ngot += int'(got);
    end
    chk("fill_got", 32'(ngot), 32'd16);
    cpu_rd(3'd0, d); chk("fill_status", 32'(d), 32'h70);
    dc = dread_cnt;
    sci_send(8'h99, 0, got);
    chk("full_no_dread", 32'(got), 32'h0);
    chk("full_dread_cnt", 32'(dread_cnt - dc), 32'h0);
    cpu_rd(3'd0, d); chk("full_status_ovr", 32'(d), 32'(8'h70 | OVR_BIT));

    // Flush clears FIFO and overrun; empty data read shows 0
    cpu_wr(3'd2, 8'h01);
    cpu_rd(3'd0, d); chk("flush_status", 32'(d), 32'h00);
    cpu_rd(3'd1, d); chk("empty_data", 32'(d), 32'h00);
    cpu_rd(3'd0, d); chk("empty_pop_status", 32'(d), 32'h00);

    // Control write with bit 0 clear is ignored
    sci_send(8'h33, 0, got);
    cpu_wr(3'd2, 8'h00);
    cpu_rd(3'd0, d); chk("noflush_status", 32'(d), 32'h21);
    cpu_rd(3'd1, d); chk("noflush_data", 32'(d), 32'h33);

    // Wrap: push 10, pop 10, push 16, pop 16
    for (int i = 0; i < 10; i++) sci_send(8'(8'h10 + i), 0, got);
    cpu_rd(3'd0, d); chk("wrap_status10", 32'(d), 32'h2A);
    for (int i = 0; i < 10; i++) begin
      cpu_rd(3'd1, d); chk("wrap_pop_a", 32'(d), 32'(8'h10 + i));
    end
    for (int i = 0; i < 16; i++) sci_send(8'(8'h20 + i), 0, got);
    cpu_rd(3'd0, d); chk("wrap_status16", 32'(d), 32'h70);
    for (int i = 0; i < 16; i++) begin
      cpu_rd(3'd1, d); chk("wrap_pop_b", 32'(d), 32'(8'h20 + i));
    end
    cpu_rd(3'd0, d); chk("wrap_status_end", 32'(d), 32'h00);

    // Push and pop in the same cycle with count 3
    for (int i = 0; i < 3; i++) sci_send(8'(8'h40 + i), 0, got);
    sci_send(8'h43, 1, got);
    chk("simul_got", 32'(got), 32'h1);
    cpu_rd(3'd0, d); chk("simul_status", 32'(d), 32'h23);
    // Read strobe held 5 cycles pops once
    @(negedge clk);
    IOsel = 1'b1; read = 1'b1; addr = 3'd1;
    #1 chk("held_data", 32'(dataout), 32'h41);
    repeat (5) @(negedge clk);
    IOsel = 1'b0; read = 1'b0; addr = 3'd0;
    cpu_rd(3'd0, d); chk("held_status", 32'(d), 32'h22);
    cpu_rd(3'd1, d); chk("held_next0", 32'(d), 32'h42);
    cpu_rd(3'd1, d); chk("held_next1", 32'(d), 32'h43);
    cpu_rd(3'd0, d); chk("held_status_end", 32'(d), 32'h00);

    // Flush in the same cycle as a push, with overrun set beforehand
    for (int i = 0; i < 16; i++) sci_send(8'(8'h60 + i), 0, got);
    sci_send(8'h98, 0, got);
    cpu_rd(3'd0, d); chk("fl_full_status", 32'(d), 32'(8'h70 | OVR_BIT));
    cpu_rd(3'd1, d); chk("fl_pop_head", 32'(d), 32'h60);
    cpu_rd(3'd0, d); chk("fl_status15", 32'(d), 32'(8'h2F | OVR_BIT));
    sci_send(8'h77, 2, got);
    chk("fl_got", 32'(got), 32'h1);
    cpu_rd(3'd0, d); chk("fl_status", 32'(d), 32'h00);
    cpu_rd(3'd1, d); chk("fl_data", 32'(d), 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
